// File: rtl/sift_sys_pkg.sv
// Shared system-phase codes and the row-fetch sequencer state type.
package sift_sys_pkg;

    localparam logic [2:0] SYS_IDLE          = 3'd0;
    localparam logic [2:0] SYS_GAUSSIAN      = 3'd1;
    localparam logic [2:0] SYS_DETECT_FILTER = 3'd2;
    localparam logic [2:0] SYS_COMPUTE_MATCH = 3'd3;
    localparam logic [2:0] SYS_END           = 3'd4;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_PRIME,
        FS_STREAM,
        FS_DRAIN,
        FS_DONE
    } fetch_state_t;

    function automatic logic is_pass_mode(input logic [2:0] mode);
        return (mode == SYS_GAUSSIAN) || (mode == SYS_DETECT_FILTER);
    endfunction

endpackage

// File: rtl/fetch_delay_pipe.sv
// Delays the {read strobe, row address} pair by the SRAM read latency.
module fetch_delay_pipe #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_re,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_re,
    output logic [ADDR_W-1:0] out_addr
);

    logic [ADDR_W:0] pipe_q [DEPTH];
    logic [ADDR_W:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = {in_re, in_addr};
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign {out_re, out_addr} = pipe_q[DEPTH-1];

endmodule

// File: rtl/line_fetch_ctrl.sv
// SRAM row-read sequencer feeding the line buffer.
// Define FETCH_STALL_CNT_EN to add the stall_cycles STREAM stall counter output.
module line_fetch_ctrl
    import sift_sys_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned PRIME_ROWS = 3,
    parameter int unsigned FLUSH_ROWS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        sys_mode,
    input  logic              stall,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [2:0]        buffer_mode,
    output logic              buffer_we,
    output logic [ADDR_W-1:0] row_idx,
    output logic              busy,
    output logic              done
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int unsigned PRIME_CNT = (NUM_ROWS < PRIME_ROWS) ? NUM_ROWS : PRIME_ROWS;
    localparam logic [ADDR_W-1:0] PRIME_LAST = ADDR_W'(PRIME_CNT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam bit                PRIME_COVERS_ALL = (PRIME_ROWS >= NUM_ROWS);
    localparam logic [7:0]        DRAIN_LAST_GAUSS = 8'(RD_LAT + FLUSH_ROWS - 1);
    localparam logic [7:0]        DRAIN_LAST_DET   = 8'(RD_LAT - 1);

    fetch_state_t      state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        drain_cnt_q, drain_cnt_d;
    logic [2:0]        buffer_mode_q, buffer_mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_issue;
    logic              start_accept;
    logic [7:0]        drain_last;

    assign start_accept = (state_q == FS_IDLE) && start && is_pass_mode(sys_mode);
    assign drain_last   = (mode_q == SYS_GAUSSIAN) ? DRAIN_LAST_GAUSS : DRAIN_LAST_DET;

    // sram_re is combinational so a stall suppresses the read in the same cycle.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        drain_cnt_d = drain_cnt_q;
        read_issue  = 1'b0;
        case (state_q)
            FS_IDLE: begin
                addr_d      = '0;
                drain_cnt_d = '0;
                if (start_accept) begin
                    state_d = FS_PRIME;
                    mode_d  = sys_mode;
                end
            end
            FS_PRIME: begin
                read_issue = 1'b1;
                if (addr_q == PRIME_LAST && PRIME_COVERS_ALL) begin
                    state_d     = FS_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    if (addr_q == PRIME_LAST) begin
                        state_d = FS_STREAM;
                    end
                end
            end
            FS_STREAM: begin
                if (!stall) begin
                    read_issue = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d     = FS_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            FS_DRAIN: begin
                if (drain_cnt_q == drain_last) begin
                    state_d = FS_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            FS_DONE: begin
                state_d = FS_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = FS_IDLE;
                addr_d  = '0;
            end
        endcase
        busy_d        = (state_d != FS_IDLE);
        done_d        = (state_d == FS_DONE);
        buffer_mode_d = busy_d ? mode_d : SYS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FS_IDLE;
            mode_q        <= SYS_IDLE;
            addr_q        <= '0;
            drain_cnt_q   <= '0;
            buffer_mode_q <= SYS_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            addr_q        <= addr_d;
            drain_cnt_q   <= drain_cnt_d;
            buffer_mode_q <= buffer_mode_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign sram_re     = read_issue;
    assign sram_addr   = addr_q;
    assign buffer_mode = buffer_mode_q;
    assign busy        = busy_q;
    assign done        = done_q;

    fetch_delay_pipe #(
        .DEPTH  (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_delay_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_re    (read_issue),
        .in_addr  (addr_q),
        .out_re   (buffer_we),
        .out_addr (row_idx)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_accept) begin
            stall_cnt_d = '0;
        end else if (state_q == FS_STREAM && stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed-vector bench for line_fetch_ctrl with default parameters.
module tb_line_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] sys_mode;
    logic       stall;
    logic       sram_re;
    logic [8:0] sram_addr;
    logic [2:0] buffer_mode;
    logic       buffer_we;
    logic [8:0] row_idx;
    logic       busy;
    logic       done;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    line_fetch_ctrl #(
        .NUM_ROWS   (8),
        .ADDR_W     (9),
        .RD_LAT     (2),
        .PRIME_ROWS (3),
        .FLUSH_ROWS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sys_mode    (sys_mode),
        .stall       (stall),
        .sram_re     (sram_re),
        .sram_addr   (sram_addr),
        .buffer_mode (buffer_mode),
        .buffer_we   (buffer_we),
        .row_idx     (row_idx),
        .busy        (busy),
        .done        (done)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int reads_before(input logic [31:0] mask, input int k);
        int n = 0;
        for (int j = 0; j < k; j++) begin
            if (mask[j]) n++;
        end
        return n;
    endfunction

    // Runs a pass; re_mask is the hand-derived set of cycles that issue a read.
    task automatic run_pass(input logic [2:0] mode, input int stall_lo, input int stall_hi,
                            input logic [31:0] re_mask, input int done_cyc);
        int   rb;
        int   exp_addr;
        logic exp_we;
        start    = 1'b1;
        sys_mode = mode;
        next_cycle();
        start    = 1'b0;
        for (int k = 0; k <= done_cyc + 1; k++) begin
            stall = (k >= stall_lo && k <= stall_hi);
            @(negedge clk);
            rb       = reads_before(re_mask, k);
            exp_addr = (k > done_cyc) ? 0 : ((rb > 7) ? 7 : rb);
            exp_we   = (k >= 2) ? re_mask[k-2] : 1'b0;
            chk("sram_re", {31'd0, sram_re}, {31'd0, re_mask[k]});
            chk("sram_addr", {23'd0, sram_addr}, exp_addr);
            chk("buffer_we", {31'd0, buffer_we}, {31'd0, exp_we});
            if (exp_we) chk("row_idx", {23'd0, row_idx}, reads_before(re_mask, k - 2));
            chk("busy", {31'd0, busy}, (k <= done_cyc) ? 32'd1 : 32'd0);
            chk("done", {31'd0, done}, (k == done_cyc) ? 32'd1 : 32'd0);
            chk("buffer_mode", {29'd0, buffer_mode}, (k <= done_cyc) ? {29'd0, mode} : 32'd0);
`ifdef FETCH_STALL_CNT_EN
            if (k == 0) chk("stall_cycles_clr", {16'd0, stall_cycles}, 32'd0);
`endif
            next_cycle();
        end
        stall = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        sys_mode = 3'd0;
        stall    = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_re", {31'd0, sram_re}, 32'd0);
        chk("rst_addr", {23'd0, sram_addr}, 32'd0);
        chk("rst_mode", {29'd0, buffer_mode}, 32'd0);
        chk("rst_we", {31'd0, buffer_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Gaussian, no stall: reads 0..7, drain 8-9, flush 10-11, done 12.
        run_pass(3'd1, -1, -1, 32'h0000_00FF, 12);
        // Detect filter, stall at addr 4 for three cycles, no flush.
        run_pass(3'd2, 4, 6, 32'h0000_078F, 13);
        // Stall throughout PRIME (ignored) and three STREAM cycles at addr 3.
        run_pass(3'd2, 0, 5, 32'h0000_07C7, 13);
`ifdef FETCH_STALL_CNT_EN
        @(negedge clk);
        chk("stall_cycles", {16'd0, stall_cycles}, 32'd3);
        next_cycle();
`endif

        // Unsupported modes are ignored in IDLE.
        start    = 1'b1;
        sys_mode = 3'd3;
        next_cycle();
        sys_mode = 3'd0;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("bad_mode_busy", {31'd0, busy}, 32'd0);
        chk("bad_mode_re", {31'd0, sram_re}, 32'd0);
        chk("bad_mode_addr", {23'd0, sram_addr}, 32'd0);
        next_cycle();

        // Start while busy is ignored; reset at addr 5 aborts the pass.
        start    = 1'b1;
        sys_mode = 3'd1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                start    = 1'b1;
                sys_mode = 3'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("busy_run_addr", {23'd0, sram_addr}, k);
            chk("busy_run_mode", {29'd0, buffer_mode}, 32'd1);
            chk("busy_run_busy", {31'd0, busy}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
            if (k == 0) chk("stall_cycles_new_start", {16'd0, stall_cycles}, 32'd0);
`endif
            next_cycle();
        end
        @(negedge clk);
        chk("pre_rst_addr", {23'd0, sram_addr}, 32'd5);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_re", {31'd0, sram_re}, 32'd0);
            chk("post_rst_addr", {23'd0, sram_addr}, 32'd0);
            chk("post_rst_we", {31'd0, buffer_we}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_mode", {29'd0, buffer_mode}, 32'd0);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            next_cycle();
        end

        // A fresh pass after the abort proves the FSM is back in IDLE.
        run_pass(3'd1, -1, -1, 32'h0000_00FF, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
